// File: rtl/picoblaze_io_pkg.sv
// Shared definitions for the pacoblaze3 I/O bridge.
// Contents:
//   DATA_W        processor port data width
//   IRQ_*_ADDR    fixed port addresses of the interrupt controller registers
//   irq_state_e   interrupt request state machine encoding
package picoblaze_io_pkg;

  localparam int DATA_W = 8;

  localparam logic [7:0] IRQ_PEND_ADDR = 8'hF0;
  localparam logic [7:0] IRQ_MASK_ADDR = 8'hF1;
  localparam logic [7:0] IRQ_CLR_ADDR  = 8'hF2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/picoblaze_irq_ctrl.sv
// Edge-triggered interrupt controller for the pacoblaze3 I/O bridge.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_irq_src      interrupt source levels, synchronous to clk
//   i_mask_we      write strobe for the mask register
//   i_clr_we       write strobe for the write-1-to-clear pending register
//   i_wdata        write data for mask / clear
//   i_ack          processor interrupt acknowledge pulse
//   o_pending      pending register
//   o_mask         mask register
//   o_state        current request state (debug visibility and request decode)
//
// Handshake: the request is held while in REQ until i_ack is seen; the
// controller then stays in SERVICE until software writes the clear register.
module picoblaze_irq_ctrl
  import picoblaze_io_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] i_irq_src,
  input  logic               i_mask_we,
  input  logic               i_clr_we,
  input  logic [NUM_IRQ-1:0] i_wdata,
  input  logic               i_ack,
  output logic [NUM_IRQ-1:0] o_pending,
  output logic [NUM_IRQ-1:0] o_mask,
  output irq_state_e         o_state
);

  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic               r_in_service;
  irq_state_e         r_state;

  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pending_nxt;
  logic [NUM_IRQ-1:0] w_mask_nxt;
  irq_state_e         w_state_nxt;

  always_comb begin
    w_edge        = i_irq_src & ~r_prev;
    w_clr         = i_clr_we ? i_wdata : '0;
    // A new edge wins over a clear of the same bit.
    w_pending_nxt = (r_pending & ~w_clr) | w_edge;
    w_mask_nxt    = i_mask_we ? i_wdata : r_mask;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (|(r_pending & r_mask) && !r_in_service) w_state_nxt = REQ;
      end
      REQ: begin
        // Look at next-cycle values so a mask/clear write withdraws the
        // request on the very next edge.
        if (i_ack)                                 w_state_nxt = SERVICE;
        else if (!(|(w_pending_nxt & w_mask_nxt))) w_state_nxt = IDLE;
      end
      SERVICE: begin
        if (i_clr_we) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // All-ones so a source already high at reset release is not an edge.
      r_prev       <= '1;
      r_pending    <= '0;
      r_mask       <= '0;
      r_in_service <= 1'b0;
      r_state      <= IDLE;
    end else begin
      r_prev       <= i_irq_src;
      r_pending    <= w_pending_nxt;
      r_mask       <= w_mask_nxt;
      // in_service tracks residence in SERVICE: set by ack, cleared by 0xF2.
      r_in_service <= (w_state_nxt == SERVICE);
      r_state      <= w_state_nxt;
    end
  end

  assign o_pending = r_pending;
  assign o_mask    = r_mask;
  assign o_state   = r_state;

endmodule

// File: rtl/picoblaze_io_bridge.sv
// I/O and interrupt front-end for a pacoblaze3 core: registered read mux,
// address-decoded output registers and an edge-triggered interrupt controller.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   port_id              processor port address
//   write_strobe         write qualifier
//   read_strobe          read qualifier (reads have no side effects)
//   out_port             processor write data
//   in_port              registered read data (1-cycle latency from port_id)
//   interrupt            interrupt request
//   interrupt_ack        processor acknowledge pulse
//   in_data              NUM_IN input channels, channel k at [8k+7:8k]
//   out_data             NUM_OUT output registers, register k at [8k+7:8k]
//   irq_src              NUM_IRQ interrupt source levels
//   out_wr_stb           (PICO_IO_WR_STROBE_EN only) one-cycle pulse per
//                        output register, aligned with its update
// Build option: define PICO_IO_WR_STROBE_EN to add out_wr_stb.
module picoblaze_io_bridge
  import picoblaze_io_pkg::*;
#(
  parameter int         NUM_IN   = 4,
  parameter int         NUM_OUT  = 3,
  parameter logic [7:0] OUT_BASE = 8'h80,
  parameter int         NUM_IRQ  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                port_id,
  input  logic                      write_strobe,
  input  logic                      read_strobe,
  input  logic [DATA_W-1:0]         out_port,
  output logic [DATA_W-1:0]         in_port,
  output logic                      interrupt,
  input  logic                      interrupt_ack,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_IRQ-1:0]        irq_src
`ifdef PICO_IO_WR_STROBE_EN
  ,
  output logic [NUM_OUT-1:0]        out_wr_stb
`endif
);

  logic [DATA_W-1:0]                r_in_port;
  logic [NUM_OUT-1:0][DATA_W-1:0]   r_out_data;

  logic [NUM_OUT-1:0] w_out_we;
  logic [DATA_W-1:0]  w_rd_data;
  logic [DATA_W-1:0]  w_pend_ext;
  logic [DATA_W-1:0]  w_mask_ext;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_mask;
  logic               w_mask_we;
  logic               w_clr_we;
  irq_state_e         w_irq_state;
  logic               w_unused_rd;

  // Reads are side-effect free, so the read qualifier carries no logic.
  assign w_unused_rd = read_strobe;

  assign w_mask_we = write_strobe && (port_id == IRQ_MASK_ADDR);
  assign w_clr_we  = write_strobe && (port_id == IRQ_CLR_ADDR);

  always_comb begin
    w_out_we = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (write_strobe && (port_id == 8'(OUT_BASE + k))) w_out_we[k] = 1'b1;
    end
  end

  always_comb begin
    w_pend_ext = '0;
    w_pend_ext[NUM_IRQ-1:0] = w_pending;
    w_mask_ext = '0;
    w_mask_ext[NUM_IRQ-1:0] = w_mask;

    // Unmapped addresses fall through to zero.
    w_rd_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (port_id == 8'(k)) w_rd_data = in_data[DATA_W*k +: DATA_W];
    end
    if (port_id == IRQ_PEND_ADDR) w_rd_data = w_pend_ext;
    if (port_id == IRQ_MASK_ADDR) w_rd_data = w_mask_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_port  <= '0;
      r_out_data <= '0;
    end else begin
      r_in_port <= w_rd_data;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_out_we[k]) r_out_data[k] <= out_port;
      end
    end
  end

  assign in_port  = r_in_port;
  assign out_data = r_out_data;

`ifdef PICO_IO_WR_STROBE_EN
  logic [NUM_OUT-1:0] r_wr_stb;

  // Registered copy of the write enables lines up with the data update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_wr_stb <= '0;
    else          r_wr_stb <= w_out_we;
  end

  assign out_wr_stb = r_wr_stb;
`else
  // No per-register write pulses in this build.
`endif

  picoblaze_irq_ctrl #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_irq_src (irq_src),
    .i_mask_we (w_mask_we),
    .i_clr_we  (w_clr_we),
    .i_wdata   (out_port[NUM_IRQ-1:0]),
    .i_ack     (interrupt_ack),
    .o_pending (w_pending),
    .o_mask    (w_mask),
    .o_state   (w_irq_state)
  );

  // Request is a pure decode of the registered state, so it is glitch-free
  // and drops asynchronously with reset.
  assign interrupt = (w_irq_state == REQ);

endmodule

// File: tb/tb_picoblaze_io_bridge.sv
// Self-checking bench for picoblaze_io_bridge (default parameters).
module tb_picoblaze_io_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  port_id = 8'h00;
  logic        write_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic [7:0]  out_port = 8'h00;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack = 1'b0;
  logic [31:0] in_data = 32'h335A2211;
  logic [23:0] out_data;
  logic [3:0]  irq_src = 4'b0000;
`ifdef PICO_IO_WR_STROBE_EN
  logic [2:0]  out_wr_stb;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  picoblaze_io_bridge dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .in_data       (in_data),
    .out_data      (out_data),
    .irq_src       (irq_src)
`ifdef PICO_IO_WR_STROBE_EN
    ,
    .out_wr_stb    (out_wr_stb)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
    port_id = addr;
    tick();
    check(name, in_port, exp);
  endtask

  typedef struct {
    logic [7:0]  pid;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  exp_in;
    logic [23:0] exp_out;
    logic [2:0]  exp_stb;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Table: one cycle per row, in_port/out_data/strobe checked after the edge.
    vecs.push_back('{8'h02, 1'b0, 8'h00, 8'h5A, 24'h000000, 3'b000, "rd_ch2"});
    vecs.push_back('{8'h40, 1'b0, 8'h00, 8'h00, 24'h000000, 3'b000, "rd_unmapped40"});
    vecs.push_back('{8'h00, 1'b0, 8'h00, 8'h11, 24'h000000, 3'b000, "rd_ch0"});
    vecs.push_back('{8'h03, 1'b0, 8'h00, 8'h33, 24'h000000, 3'b000, "rd_ch3"});
    vecs.push_back('{8'h04, 1'b0, 8'h00, 8'h00, 24'h000000, 3'b000, "rd_past_in"});
    vecs.push_back('{8'h81, 1'b1, 8'hC3, 8'h00, 24'h00C300, 3'b010, "wr_81"});
    vecs.push_back('{8'h85, 1'b1, 8'hFF, 8'h00, 24'h00C300, 3'b000, "wr_85_ignored"});
    vecs.push_back('{8'h80, 1'b1, 8'hA5, 8'h00, 24'h00C3A5, 3'b001, "wr_80"});
    vecs.push_back('{8'h82, 1'b1, 8'h7E, 8'h00, 24'h7EC3A5, 3'b100, "wr_82"});
    vecs.push_back('{8'h82, 1'b1, 8'h7E, 8'h00, 24'h7EC3A5, 3'b100, "wr_82_same"});
    vecs.push_back('{8'hF1, 1'b1, 8'hFF, 8'h00, 24'h7EC3A5, 3'b000, "wr_mask_ff"});
    vecs.push_back('{8'hF1, 1'b0, 8'h00, 8'h0F, 24'h7EC3A5, 3'b000, "rd_mask_0f"});
    vecs.push_back('{8'h7F, 1'b1, 8'h99, 8'h00, 24'h7EC3A5, 3'b000, "wr_7f_ignored"});
    vecs.push_back('{8'hF3, 1'b0, 8'h00, 8'h00, 24'h7EC3A5, 3'b000, "rd_unmapped_f3"});
    vecs.push_back('{8'hF1, 1'b1, 8'h00, 8'h0F, 24'h7EC3A5, 3'b000, "wr_mask_00"});
    vecs.push_back('{8'hF1, 1'b0, 8'h00, 8'h00, 24'h7EC3A5, 3'b000, "rd_mask_00"});
    vecs.push_back('{8'hF0, 1'b0, 8'h00, 8'h00, 24'h7EC3A5, 3'b000, "rd_pend_00"});

    // ---- reset, sources 0011 already high ----
    irq_src = 4'b0011;
    #1 reset_n = 1'b0;
    tick();
    tick();
    check("reset_in_port", in_port, 8'h00);
    check("reset_out_data", out_data, 24'h000000);
    check("reset_interrupt", interrupt, 1'b0);
    reset_n = 1'b1;
    wr(8'hF1, 8'h0F);
    port_id = 8'hF0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_src_pending", in_port, 8'h00);
      check("held_src_interrupt", interrupt, 1'b0);
    end
    irq_src = 4'b0000;
    wr(8'hF1, 8'h00);

    // ---- read latency ----
    port_id = 8'h40;
    tick();
    port_id = 8'h02;
    #1;
    check("rd_latency_before_edge", in_port, 8'h00);
    tick();
    check("rd_latency_after_edge", in_port, 8'h5A);

    // ---- table-driven read/write vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      port_id      = vecs[i].pid;
      write_strobe = vecs[i].wr;
      out_port     = vecs[i].wdata;
      exp_q.push_back(vecs[i].exp_in);
      tick();
      check({vecs[i].name, "_in_port"}, in_port, exp_q.pop_front());
      check({vecs[i].name, "_out_data"}, out_data, vecs[i].exp_out);
`ifdef PICO_IO_WR_STROBE_EN
      check({vecs[i].name, "_wr_stb"}, out_wr_stb, vecs[i].exp_stb);
`endif
    end
    write_strobe = 1'b0;
`ifdef PICO_IO_WR_STROBE_EN
    tick();
    check("wr_stb_idle", out_wr_stb, 3'b000);
`endif

    // ---- single source request / ack / clear ----
    wr(8'hF1, 8'h04);
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    check("irq2_one_cycle", interrupt, 1'b0);
    tick();
    check("irq2_two_cycles", interrupt, 1'b1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check("irq2_after_ack", interrupt, 1'b0);
    rd(8'hF0, 8'h04, "irq2_pending");
    check("irq2_service_quiet", interrupt, 1'b0);
    wr(8'hF2, 8'h04);
    rd(8'hF0, 8'h00, "irq2_cleared");
    tick();
    check("irq2_idle", interrupt, 1'b0);

    // ---- new edge while in service ----
    wr(8'hF1, 8'h05);
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    tick();
    check("svc_req", interrupt, 1'b1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    irq_src = 4'b0001;
    tick();
    irq_src = 4'b0000;
    tick();
    check("svc_blocked_1", interrupt, 1'b0);
    tick();
    check("svc_blocked_2", interrupt, 1'b0);
    rd(8'hF0, 8'h05, "svc_pending_05");
    wr(8'hF2, 8'h04);
    check("svc_clear_idle", interrupt, 1'b0);
    tick();
    check("svc_reentry", interrupt, 1'b1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    wr(8'hF2, 8'h01);
    check("svc_final_idle", interrupt, 1'b0);
    rd(8'hF0, 8'h00, "svc_pending_00");

    // ---- set beats clear, mask withdrawal, reset mid-request ----
    wr(8'hF1, 8'h00);
    irq_src = 4'b0010;
    tick();
    irq_src = 4'b0000;
    tick();
    port_id      = 8'hF2;
    out_port     = 8'h02;
    write_strobe = 1'b1;
    irq_src      = 4'b0010;
    tick();
    write_strobe = 1'b0;
    irq_src      = 4'b0000;
    rd(8'hF0, 8'h02, "set_beats_clear");
    wr(8'hF1, 8'h02);
    check("mask_on_no_req_yet", interrupt, 1'b0);
    tick();
    check("mask_on_req", interrupt, 1'b1);
    wr(8'hF1, 8'h00);
    check("mask_off_drops", interrupt, 1'b0);
    wr(8'hF1, 8'h02);
    tick();
    check("req_before_reset", interrupt, 1'b1);
    check("in_port_before_reset", in_port, 8'h02);
    reset_n = 1'b0;
    #1;
    check("async_reset_interrupt", interrupt, 1'b0);
    check("async_reset_in_port", in_port, 8'h00);
    check("async_reset_out_data", out_data, 24'h000000);
    tick();
    reset_n = 1'b1;
    rd(8'hF0, 8'h00, "post_reset_pending");
    rd(8'hF1, 8'h00, "post_reset_mask");
    tick();
    check("post_reset_interrupt", interrupt, 1'b0);

    // ---- report ----
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/picoblaze_io_bridge.md
Name: picoblaze_io_bridge

Overview:
Parametrised I/O and interrupt front-end for a pacoblaze3 core, replacing hand-written per-project port muxes and output registers.
- Provides NUM_IN registered input channels and NUM_OUT output registers, all fully address-decoded.
- Includes a NUM_IRQ-source edge-triggered interrupt controller with pending, mask and clear registers.
- Sits between the pacoblaze3 instance and the project datapath (calculator / speech control FSMs).

Parameters:
- NUM_IN, 4, number of 8-bit input channels, read at port_id 0x00..NUM_IN-1; legal range 1..16.
- NUM_OUT, 3, number of 8-bit output registers, written at OUT_BASE..OUT_BASE+NUM_OUT-1; legal range 1..16.
- OUT_BASE, 8'h80, base port address of the output registers; must be 16-aligned and not 0xF0.
- NUM_IRQ, 4, number of interrupt sources; legal range 1..8.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- port_id  in  8  processor port address
- write_strobe  in  1  processor write qualifier
- read_strobe  in  1  processor read qualifier (informational; reads are not side-effecting)
- out_port  in  8  processor write data
- in_port  out  8  registered read data to processor
- interrupt  out  1  interrupt request to processor
- interrupt_ack  in  1  processor acknowledge pulse
- in_data  in  NUM_IN*8  input channels, channel k at [8k+7:8k]
- out_data  out  NUM_OUT*8  output registers, register k at [8k+7:8k]
- irq_src  in  NUM_IRQ  interrupt sources, level signals synchronous to clk

Behaviour:
Reset values:
- in_port, out_data, irq_pending, irq_mask, in_service and interrupt all reset to 0.
- irq_prev resets to all-ones, so a source already high at reset release raises no edge.

Read mux:
- in_port is registered from port_id, giving 1-cycle latency independent of read_strobe.
- 0x00..NUM_IN-1 returns in_data channel.
- 0xF0 returns irq_pending, zero-extended.
- 0xF1 returns irq_mask, zero-extended.
- Every other address returns 0x00, never X.

Writes (only when write_strobe=1; port_id must match exactly):
- OUT_BASE+k loads out_data[k] on the next edge; the value holds until rewritten.
- 0xF1 loads irq_mask from out_port[NUM_IRQ-1:0].
- 0xF2 is write-1-to-clear of irq_pending; any write to 0xF2 also clears in_service.
- Writes to unmapped addresses are ignored.

Interrupt controller:
- Each cycle: irq_prev <= irq_src; edge = irq_src & ~irq_prev.
- irq_pending <= (irq_pending & ~clr) | edge, where clr is nonzero only on a 0xF2 write. Set wins over clear for the same bit in the same cycle.
- Edges on masked sources still set pending; the mask gates only the request.
- State machine:
  - IDLE: interrupt=0. Move to REQ when |(irq_pending & irq_mask) and !in_service.
  - REQ: interrupt=1. On interrupt_ack, interrupt=0, set in_service, move to SERVICE.
  - SERVICE: interrupt=0. On a 0xF2 write, clear in_service and return to IDLE; re-entry to REQ happens on the following cycle if any masked pending bit remains.
- interrupt_ack seen in IDLE or SERVICE is ignored.
- A mask write that zeroes all pending bits while in REQ returns to IDLE, dropping interrupt on the next edge.
- Reset asserted mid-operation returns the controller to IDLE with all registers at their reset values, asynchronously.

Optional Feature:
Macro PICO_IO_WR_STROBE_EN.
- Defined: adds output port out_wr_stb [NUM_OUT-1:0]. Bit k pulses high for exactly one cycle, coincident with the cycle out_data[k] updates. Reset value 0. Lets datapath FSMs detect a "done" rewrite of the same value.
- Undefined: the port and its logic are absent; everything else is unchanged.

Decomposition:
- Package picoblaze_io_pkg holds:
  - port address constants: IRQ_PEND_ADDR=8'hF0, IRQ_MASK_ADDR=8'hF1, IRQ_CLR_ADDR=8'hF2;
  - DATA_W=8;
  - the IRQ state enum {IDLE, REQ, SERVICE}.
- One sub-module, picoblaze_irq_ctrl: edge detect, pending, mask, state machine. The top level keeps the read mux and output registers.

Test Plan:
1. Reset release with irq_src=4'b0011 held high, mask=0x0F: pending stays 0x00 and interrupt stays 0 for 10 cycles.
2. in_data ch2=0x5A, port_id=0x02: in_port=0x5A exactly one cycle later. port_id=0x40 (unmapped): in_port=0x00.
3. Write 0xC3 to 0x81: out_data[1]=0xC3 on the next edge, others unchanged. Write to 0x85 with NUM_OUT=3: no register changes. With PICO_IO_WR_STROBE_EN, out_wr_stb=3'b010 for one cycle.
4. mask=0x04, pulse irq_src[2]: interrupt=1 two cycles after the edge. interrupt_ack → interrupt=0, a read of 0xF0 returns 0x04. Write 0x04 to 0xF2 → pending=0, IDLE.
5. In SERVICE, new edge on src0 (mask=0x05): no interrupt until the 0xF2 write clearing bit 2, then interrupt=1 for the pending 0x01.
6. Edge on src1 in the same cycle as a 0xF2 write of 0x02: pending bit1 remains 1. Assert reset_n=0 while in REQ: interrupt drops immediately and all registers read 0.
